// File: rtl/mips_defs.sv
// Shared MIPS encodings for the decode stage: opcodes, functs, ALU codes and
// the control/pipeline-register bundles handed to execute.
package mips_defs;

    localparam int NB_DATA_W = 32;
    localparam int NB_REG_W  = 5;
    localparam int NB_OP_W   = 6;

    localparam logic [NB_REG_W-1:0] REG_RA = 5'd31;

    typedef enum logic [NB_OP_W-1:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_SLTI  = 6'b001010,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_LUI   = 6'b001111,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [NB_OP_W-1:0] {
        FN_SLL  = 6'b000000,
        FN_SRL  = 6'b000010,
        FN_SRA  = 6'b000011,
        FN_SLLV = 6'b000100,
        FN_SRLV = 6'b000110,
        FN_SRAV = 6'b000111,
        FN_JR   = 6'b001000,
        FN_JALR = 6'b001001,
        FN_ADDU = 6'b100001,
        FN_SUBU = 6'b100011,
        FN_AND  = 6'b100100,
        FN_OR   = 6'b100101,
        FN_XOR  = 6'b100110,
        FN_NOR  = 6'b100111,
        FN_SLT  = 6'b101010
    } funct_e;

    localparam logic [NB_OP_W-1:0] ALU_ADD = 6'b100000;
    localparam logic [NB_OP_W-1:0] ALU_AND = 6'b100100;
    localparam logic [NB_OP_W-1:0] ALU_OR  = 6'b100101;
    localparam logic [NB_OP_W-1:0] ALU_XOR = 6'b100110;
    localparam logic [NB_OP_W-1:0] ALU_SLT = 6'b101010;

    typedef struct packed {
        logic [NB_OP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               link;
    } ctrl_t;

    typedef struct packed {
        logic [NB_DATA_W-1:0] pc_next;
        logic [NB_DATA_W-1:0] rs_data;
        logic [NB_DATA_W-1:0] rt_data;
        logic [NB_DATA_W-1:0] immediate;
        logic [NB_REG_W-1:0]  rs;
        logic [NB_REG_W-1:0]  rt;
        logic [NB_REG_W-1:0]  write_register;
        logic [4:0]           shamt;
        ctrl_t                ctrl;
    } id_ex_t;

    // I-type instructions reuse the R-type funct codes as their ALU operation.
    function automatic logic [NB_OP_W-1:0] imm_alu_op(input opcode_e op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_XORI: return ALU_XOR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32-entry register file: two combinational read ports with write-through
// bypass, one write port, r0 hardwired to zero.
module register_file #(
    parameter int NB_DATA     = 32,
    parameter int NB_REGISTER = 5,
    parameter int N_REGISTERS = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_write_enable,
    input  logic [NB_REGISTER-1:0] i_write_register,
    input  logic [NB_DATA-1:0]     i_write_data,
    input  logic [NB_REGISTER-1:0] i_read_register_a,
    input  logic [NB_REGISTER-1:0] i_read_register_b,
    output logic [NB_DATA-1:0]     o_read_data_a,
    output logic [NB_DATA-1:0]     o_read_data_b
);

    logic [NB_DATA-1:0] regs_q [N_REGISTERS];
    logic [NB_DATA-1:0] regs_d [N_REGISTERS];

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        regs_d = regs_q;
        if (i_write_enable && i_write_register != '0) begin
            regs_d[i_write_register] = i_write_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: the array is reset because software may read any register before writing it.
            for (int i = 0; i < N_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: flops use <= so every register samples pre-edge values.
            regs_q <= regs_d;
        end
    end

    always_comb begin
        o_read_data_a = regs_q[i_read_register_a];
        if (i_read_register_a == '0) begin
            o_read_data_a = '0;
        end else if (i_write_enable && i_write_register == i_read_register_a) begin
            o_read_data_a = i_write_data;
        end
    end

    always_comb begin
        o_read_data_b = regs_q[i_read_register_b];
        if (i_read_register_b == '0) begin
            o_read_data_b = '0;
        end else if (i_write_enable && i_write_register == i_read_register_b) begin
            o_read_data_b = i_write_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: register file, instruction decode, immediate extension,
// branch/jump resolution back to fetch, and the ID/EX pipeline register.
module decode_stage
    import mips_defs::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REGISTER = 5,
    parameter int N_REGISTERS = 32,
    parameter int NB_OPCODE   = 6
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_DATA-1:0]     i_instruction,
    input  logic [NB_DATA-1:0]     i_pc_next,
    input  logic                   i_stall,
    input  logic                   i_wb_write,
    input  logic [NB_REGISTER-1:0] i_wb_register,
    input  logic [NB_DATA-1:0]     i_wb_data,
    output logic                   o_branch_taken,
    output logic [NB_DATA-1:0]     o_branch_target,
    output logic [NB_DATA-1:0]     o_pc_next,
    output logic [NB_DATA-1:0]     o_rs_data,
    output logic [NB_DATA-1:0]     o_rt_data,
    output logic [NB_DATA-1:0]     o_immediate,
    output logic [NB_REGISTER-1:0] o_rs,
    output logic [NB_REGISTER-1:0] o_rt,
    output logic [NB_REGISTER-1:0] o_write_register,
    output logic [4:0]             o_shamt,
    output logic [NB_OPCODE-1:0]   o_alu_op,
    output logic                   o_alu_src,
    output logic                   o_reg_write,
    output logic                   o_mem_read,
    output logic                   o_mem_write,
    output logic                   o_mem_to_reg,
    output logic                   o_link
);

    logic [NB_OPCODE-1:0]   opcode;
    logic [NB_OPCODE-1:0]   funct;
    logic [NB_REGISTER-1:0] rs_idx;
    logic [NB_REGISTER-1:0] rt_idx;
    logic [NB_REGISTER-1:0] rd_idx;
    logic [15:0]            imm16;
    logic [NB_DATA-1:0]     imm_sext;
    logic [NB_DATA-1:0]     imm_ext;
    logic [NB_DATA-1:0]     rs_data;
    logic [NB_DATA-1:0]     rt_data;
    logic                   wb_enable;
    logic                   branch_hit;
    logic [NB_DATA-1:0]     branch_target;
    logic [NB_REGISTER-1:0] dest;
    ctrl_t                  ctrl;
    id_ex_t                 id_ex_d;
    id_ex_t                 id_ex_q;

    assign opcode    = i_instruction[31:26];
    assign rs_idx    = i_instruction[25:21];
    assign rt_idx    = i_instruction[20:16];
    assign rd_idx    = i_instruction[15:11];
    assign funct     = i_instruction[5:0];
    assign imm16     = i_instruction[15:0];
    assign imm_sext  = {{(NB_DATA-16){imm16[15]}}, imm16};
    assign wb_enable = i_valid & i_wb_write;

    register_file #(
        .NB_DATA     (NB_DATA),
        .NB_REGISTER (NB_REGISTER),
        .N_REGISTERS (N_REGISTERS)
    ) u_register_file (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_write_enable    (wb_enable),
        .i_write_register  (i_wb_register),
        .i_write_data      (i_wb_data),
        .i_read_register_a (rs_idx),
        .i_read_register_b (rt_idx),
        .o_read_data_a     (rs_data),
        .o_read_data_b     (rt_data)
    );

    always_comb begin
        ctrl          = '0;
        dest          = '0;
        imm_ext       = imm_sext;
        branch_hit    = 1'b0;
        branch_target = i_pc_next + imm_sext;

        case (opcode_e'(opcode))
            OP_RTYPE: begin
                case (funct_e'(funct))
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: begin
                        ctrl.alu_op    = funct;
                        ctrl.reg_write = 1'b1;
                        dest           = rd_idx;
                    end
                    FN_JR: begin
                        ctrl.alu_op   = funct;
                        branch_hit    = 1'b1;
                        branch_target = rs_data;
                    end
                    FN_JALR: begin
                        ctrl.alu_op    = funct;
                        ctrl.reg_write = 1'b1;
                        ctrl.link      = 1'b1;
                        dest           = rd_idx;
                        branch_hit     = 1'b1;
                        branch_target  = rs_data;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.alu_op    = imm_alu_op(opcode_e'(opcode));
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                dest           = rt_idx;
                if (opcode_e'(opcode) == OP_LUI) begin
                    imm_ext = {imm16, {(NB_DATA-16){1'b0}}};
                end else if (opcode_e'(opcode) != OP_ADDI && opcode_e'(opcode) != OP_SLTI) begin
                    imm_ext = {{(NB_DATA-16){1'b0}}, imm16};
                end
            end
            OP_LW: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                dest            = rt_idx;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: branch_hit = (rs_data == rt_data);
            OP_BNE: branch_hit = (rs_data != rt_data);
            OP_J, OP_JAL: begin
                branch_hit    = 1'b1;
                branch_target = {i_pc_next[NB_DATA-1:26], i_instruction[25:0]};
                if (opcode_e'(opcode) == OP_JAL) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.link      = 1'b1;
                    dest           = REG_RA;
                end
            end
            default: ;
        endcase

        // A write to r0 is architecturally a no-op; keep it out of the pipeline.
        if (dest == '0) begin
            ctrl.reg_write = 1'b0;
        end
    end

    assign o_branch_taken  = branch_hit & ~i_stall;
    assign o_branch_target = branch_target;

    always_comb begin
        id_ex_d = id_ex_q;
        if (i_valid) begin
            if (i_stall) begin
                id_ex_d.ctrl = '0;
            end else begin
                id_ex_d.pc_next        = i_pc_next;
                id_ex_d.rs_data        = rs_data;
                id_ex_d.rt_data        = rt_data;
                id_ex_d.immediate      = imm_ext;
                id_ex_d.rs             = rs_idx;
                id_ex_d.rt             = rt_idx;
                id_ex_d.write_register = dest;
                id_ex_d.shamt          = i_instruction[10:6];
                id_ex_d.ctrl           = ctrl;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign o_pc_next        = id_ex_q.pc_next;
    assign o_rs_data        = id_ex_q.rs_data;
    assign o_rt_data        = id_ex_q.rt_data;
    assign o_immediate      = id_ex_q.immediate;
    assign o_rs             = id_ex_q.rs;
    assign o_rt             = id_ex_q.rt;
    assign o_write_register = id_ex_q.write_register;
    assign o_shamt          = id_ex_q.shamt;
    assign o_alu_op         = id_ex_q.ctrl.alu_op;
    assign o_alu_src        = id_ex_q.ctrl.alu_src;
    assign o_reg_write      = id_ex_q.ctrl.reg_write;
    assign o_mem_read       = id_ex_q.ctrl.mem_read;
    assign o_mem_write      = id_ex_q.ctrl.mem_write;
    assign o_mem_to_reg     = id_ex_q.ctrl.mem_to_reg;
    assign o_link           = id_ex_q.ctrl.link;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a MIPS reference model predicts the
// combinational branch result and the next ID/EX contents for every step.
module tb_decode_stage;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_instruction = '0;
    logic [31:0] i_pc_next = '0;
    logic        i_stall = 1'b0;
    logic        i_wb_write = 1'b0;
    logic [4:0]  i_wb_register = '0;
    logic [31:0] i_wb_data = '0;

    logic        o_branch_taken;
    logic [31:0] o_branch_target, o_pc_next, o_rs_data, o_rt_data, o_immediate;
    logic [4:0]  o_rs, o_rt, o_write_register, o_shamt;
    logic [5:0]  o_alu_op;
    logic        o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_link;

    decode_stage dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .i_instruction    (i_instruction),
        .i_pc_next        (i_pc_next),
        .i_stall          (i_stall),
        .i_wb_write       (i_wb_write),
        .i_wb_register    (i_wb_register),
        .i_wb_data        (i_wb_data),
        .o_branch_taken   (o_branch_taken),
        .o_branch_target  (o_branch_target),
        .o_pc_next        (o_pc_next),
        .o_rs_data        (o_rs_data),
        .o_rt_data        (o_rt_data),
        .o_immediate      (o_immediate),
        .o_rs             (o_rs),
        .o_rt             (o_rt),
        .o_write_register (o_write_register),
        .o_shamt          (o_shamt),
        .o_alu_op         (o_alu_op),
        .o_alu_src        (o_alu_src),
        .o_reg_write      (o_reg_write),
        .o_mem_read       (o_mem_read),
        .o_mem_write      (o_mem_write),
        .o_mem_to_reg     (o_mem_to_reg),
        .o_link           (o_link)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, wr, sh;
        logic [5:0]  op;
        logic        src, rw, mr, mw, m2r, lk;
    } exp_t;

    typedef struct packed {
        logic        tk;
        logic [31:0] tgt;
    } br_t;

    exp_t        reg_q[$];
    br_t         br_q[$];
    exp_t        model_state = '0;
    logic [31:0] model_rf [32];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [159:0] dut_vec();
        return {o_pc_next, o_rs_data, o_rt_data, o_immediate, o_rs, o_rt, o_write_register,
                o_shamt, o_alu_op, o_alu_src, o_reg_write, o_mem_read, o_mem_write,
                o_mem_to_reg, o_link};
    endfunction

    // Architectural read as seen in ID: r0 is zero, a same-cycle writeback wins.
    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (i_valid && i_wb_write && i_wb_register == idx) return i_wb_data;
        return model_rf[idx];
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pcn,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output exp_t e, output logic tk, output logic [31:0] tgt);
        logic [5:0] op  = ins[31:26];
        logic [5:0] fn  = ins[5:0];
        logic [4:0] rd  = ins[15:11];
        int         s16 = $signed(ins[15:0]);
        e     = '0;
        e.pc  = pcn;
        e.a   = a;
        e.b   = b;
        e.rs  = ins[25:21];
        e.rt  = ins[20:16];
        e.sh  = ins[10:6];
        e.imm = 32'(s16);
        tk    = 1'b0;
        tgt   = pcn + 32'(s16);
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
                           6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) begin
                e.op = fn; e.rw = 1'b1; e.wr = rd;
            end else if (fn == 6'h08) begin
                e.op = fn; tk = 1'b1; tgt = a;
            end else if (fn == 6'h09) begin
                e.op = fn; e.rw = 1'b1; e.lk = 1'b1; e.wr = rd; tk = 1'b1; tgt = a;
            end
        end else begin
            case (op)
                6'h08: begin e.op = 6'h20; e.src = 1; e.rw = 1; e.wr = e.rt; end
                6'h0A: begin e.op = 6'h2A; e.src = 1; e.rw = 1; e.wr = e.rt; end
                6'h0C: begin e.op = 6'h24; e.src = 1; e.rw = 1; e.wr = e.rt; e.imm = {16'h0, ins[15:0]}; end
                6'h0D: begin e.op = 6'h25; e.src = 1; e.rw = 1; e.wr = e.rt; e.imm = {16'h0, ins[15:0]}; end
                6'h0E: begin e.op = 6'h26; e.src = 1; e.rw = 1; e.wr = e.rt; e.imm = {16'h0, ins[15:0]}; end
                6'h0F: begin e.op = 6'h20; e.src = 1; e.rw = 1; e.wr = e.rt; e.imm = {ins[15:0], 16'h0}; end
                6'h23: begin e.op = 6'h20; e.src = 1; e.rw = 1; e.mr = 1; e.m2r = 1; e.wr = e.rt; end
                6'h2B: begin e.op = 6'h20; e.src = 1; e.mw = 1; end
                6'h04: tk = (a == b);
                6'h05: tk = (a != b);
                6'h02: begin tk = 1; tgt = {pcn[31:26], ins[25:0]}; end
                6'h03: begin tk = 1; tgt = {pcn[31:26], ins[25:0]}; e.wr = 5'd31; e.rw = 1; e.lk = 1; end
                default: ;
            endcase
        end
        if (e.wr == 0) e.rw = 1'b0;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue its predictions.
    task automatic step(input logic v, input logic st, input logic [31:0] ins, input logic [31:0] pcn,
                        input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
        exp_t        e;
        logic        tk;
        logic [31:0] tgt;
        i_valid       = v;
        i_stall       = st;
        i_instruction = ins;
        i_pc_next     = pcn;
        i_wb_write    = wbw;
        i_wb_register = wbr;
        i_wb_data     = wbd;
        ref_decode(ins, pcn, rf_read(ins[25:21]), rf_read(ins[20:16]), e, tk, tgt);
        br_q.push_back('{tk: tk & ~st, tgt: tgt});
        if (v) begin
            if (st) begin
                model_state.op  = '0;
                model_state.src = 1'b0;
                model_state.rw  = 1'b0;
                model_state.mr  = 1'b0;
                model_state.mw  = 1'b0;
                model_state.m2r = 1'b0;
                model_state.lk  = 1'b0;
            end else begin
                model_state = e;
            end
            if (wbw && wbr != 0) model_rf[wbr] = wbd;
        end
        reg_q.push_back(model_state);
        @(negedge i_clock);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [12] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom());
        int          pick = $urandom_range(0, 9);
        if (pick == 0) return $urandom();
        if (pick <= 3) return {6'h00, rs, rt, rd, 5'($urandom()), fns[$urandom_range(0, 15)]};
        return {ops[$urandom_range(0, 11)], rs, rt, imm};
    endfunction

    // Monitor: branch outputs mid-cycle, pipeline register just after each rising edge.
    initial begin
        br_t  b;
        exp_t e;
        forever begin
            @(negedge i_clock);
            #2;
            if (br_q.size() > 0) begin
                b = br_q.pop_front();
                check("branch_taken", 160'(o_branch_taken), 160'(b.tk));
                if (b.tk) check("branch_target", 160'(o_branch_target), 160'(b.tgt));
            end
            @(posedge i_clock);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                check("id_ex", dut_vec(), e);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        repeat (2) @(negedge i_clock);
        check("reset_outputs", dut_vec(), '0);
        i_reset = 1'b0;

        // Writeback then ADDU r3,r1,r2; bypass on r1; r0 stays zero.
        step(1, 0, 32'h0000_0000, 32'h0000_0001, 1, 5'd1, 32'd5);
        step(1, 0, 32'h0000_0000, 32'h0000_0002, 1, 5'd2, 32'd7);
        step(1, 0, 32'h0022_1821, 32'h0000_0003, 0, 5'd0, 32'd0);
        step(1, 0, 32'h0022_1821, 32'h0000_0004, 1, 5'd1, 32'hAA);
        step(1, 0, 32'h0000_0000, 32'h0000_0005, 1, 5'd0, 32'h1234);
        step(1, 0, 32'h0000_1821, 32'h0000_0006, 0, 5'd0, 32'd0);

        // BEQ r1,r2,-3 taken, then ORI / ADDI / JAL immediates and link.
        step(1, 0, 32'h0000_0000, 32'h0000_0007, 1, 5'd1, 32'd4);
        step(1, 0, 32'h0000_0000, 32'h0000_0008, 1, 5'd2, 32'd4);
        step(1, 0, 32'h1022_FFFD, 32'h0000_0010, 0, 5'd0, 32'd0);
        step(1, 0, 32'h3421_FFFF, 32'h0000_0011, 0, 5'd0, 32'd0);
        step(1, 0, 32'h2021_FFFF, 32'h0000_0012, 0, 5'd0, 32'd0);
        step(1, 0, 32'h0C00_0040, 32'hA400_0013, 0, 5'd0, 32'd0);

        // Stall while a taken BEQ and an LW sit in ID.
        step(1, 1, 32'h1022_FFFD, 32'h0000_0020, 0, 5'd0, 32'd0);
        step(1, 0, 32'h8C22_0004, 32'h0000_0021, 0, 5'd0, 32'd0);
        step(1, 1, 32'h8C22_0004, 32'h0000_0022, 0, 5'd0, 32'd0);

        // Freeze with writeback active, then read the register back.
        step(1, 0, 32'h0000_0000, 32'h0000_0030, 1, 5'd5, 32'h55);
        repeat (3) step(0, 0, 32'h00A0_3021, 32'h0000_0031, 1, 5'd5, 32'hDEAD);
        step(1, 0, 32'h00A0_3021, 32'h0000_0032, 0, 5'd0, 32'd0);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10, rand_instr(), $urandom(),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
        end

        // Asynchronous reset between edges must clear outputs before the next edge.
        @(posedge i_clock);
        #3;
        i_reset = 1'b1;
        #1;
        check("async_reset", dut_vec(), '0);
        @(negedge i_clock);
        i_reset = 1'b0;
        model_state = '0;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        step(1, 0, 32'h0022_1821, 32'h0000_0040, 0, 5'd0, 32'd0);
        step(1, 0, 32'h8C22_0004, 32'h0000_0041, 1, 5'd2, 32'h77);

        repeat (2) @(negedge i_clock);
        check("queues_drained", 160'(reg_q.size() + br_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
